// File: rtl/serdes_rx_aligner.sv
// serdes_rx_aligner: pulses ISERDES BITSLIP until the registered word matches
// the training pattern, then holds lock and counts mismatching words.
module serdes_rx_aligner #(
   parameter int              DATA_WIDTH    = 8,
   parameter logic [7:0]      TRAIN_PATTERN = 8'hB4,
   parameter int              SETTLE_CYCLES = 4,
   parameter int              MATCH_COUNT   = 16,
   parameter int              MAX_SLIPS     = 16
) (
   input  logic                  CLKDIV,
   input  logic                  RST,
   input  logic                  RESTART,
   input  logic [DATA_WIDTH-1:0] DATA_IN,
   output logic                  BITSLIP,
   output logic                  ALIGNED,
   output logic                  ALIGN_FAIL,
   output logic [4:0]            SLIP_CNT,
   output logic [15:0]           ERR_CNT
);
   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int MW = (MATCH_COUNT > 1) ? $clog2(MATCH_COUNT) : 1;
   localparam logic [DATA_WIDTH-1:0] PAT         = TRAIN_PATTERN[DATA_WIDTH-1:0];
   localparam logic [SW-1:0]         SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
   localparam logic [MW-1:0]         MATCH_LAST  = MW'(MATCH_COUNT - 1);
   localparam logic [4:0]            SLIP_LIMIT  = 5'(MAX_SLIPS);
   typedef enum logic [2:0] {SETTLE, CHECK, SLIP, LOCKED, FAIL} state_t;
   state_t                state_q;
   logic [DATA_WIDTH-1:0] d_q;
   logic [SW-1:0]         settle_q;
   logic [MW-1:0]         match_q;
   logic                  bitslip_q, aligned_q, fail_q;
   logic [4:0]            slip_q;
   logic [15:0]           err_q;
   logic                  hit;
   assign hit        = d_q == PAT;
   assign BITSLIP    = bitslip_q;
   assign ALIGNED    = aligned_q;
   assign ALIGN_FAIL = fail_q;
   assign SLIP_CNT   = slip_q;
   assign ERR_CNT    = err_q;
   always_ff @(posedge CLKDIV) begin
      d_q <= DATA_IN;
      if (RST || RESTART) begin
         state_q   <= SETTLE;
         settle_q  <= '0;
         match_q   <= '0;
         bitslip_q <= 1'b0;
         aligned_q <= 1'b0;
         fail_q    <= 1'b0;
         slip_q    <= '0;
         err_q     <= '0;
      end else begin
         bitslip_q <= 1'b0;
         case (state_q)
            SETTLE: begin
               settle_q <= (settle_q == SETTLE_LAST) ? '0 : settle_q + 1'b1;
               match_q  <= '0;
               state_q  <= (settle_q == SETTLE_LAST) ? CHECK : SETTLE;
            end
            CHECK: begin
               match_q   <= (hit && match_q != MATCH_LAST) ? match_q + 1'b1 : '0;
               aligned_q <= hit && match_q == MATCH_LAST;
               fail_q    <= !hit && slip_q == SLIP_LIMIT;
               // A slip is issued on the same edge that leaves CHECK, so the pulse lasts exactly the SLIP cycle
               bitslip_q <= !hit && slip_q != SLIP_LIMIT;
               slip_q    <= (!hit && slip_q != SLIP_LIMIT) ? slip_q + 1'b1 : slip_q;
               state_q   <= hit ? ((match_q == MATCH_LAST) ? LOCKED : CHECK)
                                : ((slip_q == SLIP_LIMIT) ? FAIL : SLIP);
            end
            SLIP:    state_q <= SETTLE;
            LOCKED:  err_q   <= (!hit && err_q != 16'hFFFF) ? err_q + 1'b1 : err_q;
            FAIL:    state_q <= FAIL;
            default: state_q <= SETTLE;
         endcase
      end
   end
endmodule
